// File: rtl/mvau_defn.sv
// Shared definitions for the MVAU activation scheduler: default geometry,
// scheduler state type and address-width helpers.
package mvau_defn;

  // Default layer geometry; SF and NF are derived from the matrix shape.
  localparam int TSRC_I   = 1;
  localparam int SIMD     = 8;
  localparam int PE       = 4;
  localparam int MATRIX_W = 32;
  localparam int MATRIX_H = 12;

  localparam int TI_DEF = TSRC_I * SIMD;
  localparam int SF_DEF = MATRIX_W / SIMD;
  localparam int NF_DEF = MATRIX_H / PE;

  // FILL takes words from the input stream, REPLAY re-reads the buffer.
  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } sched_state_e;

  // Counter width able to index n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Weight memory address width for SF*NF weight words per vector.
  function automatic int wmem_addr_bw(input int sf, input int nf);
    return clog2_min1(sf * nf);
  endfunction

endpackage

// File: rtl/mvau_act_buf.sv
// SF-deep activation buffer: one synchronous write port, one combinational
// read port, no reset, so it maps onto distributed RAM.
module mvau_act_buf
  import mvau_defn::*;
#(
  parameter int TI = TI_DEF,
  parameter int SF = SF_DEF,
  parameter int AW = clog2_min1(SF)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [TI-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [TI-1:0] rdata
);

  logic [TI-1:0] mem [SF];

  // Store one activation word per accepted input beat.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mvau_act_sched.sv
// Activation scheduler and weight-address sequencer. One input vector
// (SF words) is captured while it streams through, then replayed from the
// local buffer for the remaining NF-1 PE folds. wmem_addr leads act_out by
// one cycle so a registered weight memory lines up with the activation.
//
// Handshake: an input word transfers on a rising edge where in_v and in_rdy
// are both high; in_rdy depends only on state and out_rdy. out_rdy low stops
// new issues at the next edge, while up to two beats already in the
// pipeline still emerge, so the consumer needs two entries of skid.
module mvau_act_sched
  import mvau_defn::*;
#(
  parameter int TI           = TI_DEF,
  parameter int SF           = SF_DEF,
  parameter int NF           = NF_DEF,
  parameter int WMEM_ADDR_BW = wmem_addr_bw(SF, NF)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TI-1:0]           in,
  input  logic                    in_v,
  output logic                    in_rdy,
  input  logic                    out_rdy,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic                    addr_v,
  output logic [TI-1:0]           act_out,
  output logic                    act_v,
  output logic                    act_last,
  output logic                    vec_done,
  output logic                    busy
);

  localparam int SFW = clog2_min1(SF);
  localparam int NFW = clog2_min1(NF);
  localparam logic [SFW-1:0]          SF_LAST   = SFW'(SF - 1);
  localparam logic [NFW-1:0]          NF_LAST   = NFW'(NF - 1);
  localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(SF * NF - 1);

  sched_state_e            state;
  logic [SFW-1:0]          sf_cnt;
  logic [NFW-1:0]          nf_cnt;
  logic [WMEM_ADDR_BW-1:0] addr_cnt;
  logic                    issue;
  logic                    sf_wrap;
  logic                    nf_wrap;
  logic                    buf_we;
  logic [TI-1:0]           buf_rd;
  logic [TI-1:0]           data_s1;
  logic                    last_s1;
  logic                    done_s1;

  assign in_rdy  = (state == FILL) & out_rdy;
  assign issue   = (state == FILL) ? (in_v & in_rdy) : out_rdy;
  assign sf_wrap = (sf_cnt == SF_LAST);
  assign nf_wrap = (nf_cnt == NF_LAST);
  assign buf_we  = issue & (state == FILL);

  mvau_act_buf #(
    .TI (TI),
    .SF (SF),
    .AW (SFW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (sf_cnt),
    .wdata (in),
    .raddr (sf_cnt),
    .rdata (buf_rd)
  );

  // Fold counters, flat weight address counter and FILL/REPLAY state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      busy     <= 1'b0;
      sf_cnt   <= '0;
      nf_cnt   <= '0;
      addr_cnt <= '0;
    end else if (issue) begin
      sf_cnt   <= sf_wrap ? '0 : sf_cnt + SFW'(1);
      addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + WMEM_ADDR_BW'(1);
      if (sf_wrap) nf_cnt <= nf_wrap ? '0 : nf_cnt + NFW'(1);
      if (state == FILL && sf_wrap && NF > 1) begin
        state <= REPLAY;
        busy  <= 1'b1;
      end else if (state == REPLAY && sf_wrap && nf_wrap) begin
        state <= FILL;
        busy  <= 1'b0;
      end
    end
  end

  // Stage 1: weight address plus the activation word and its fold flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_v    <= 1'b0;
      wmem_addr <= '0;
      data_s1   <= '0;
      last_s1   <= 1'b0;
      done_s1   <= 1'b0;
    end else if (issue) begin
      addr_v    <= 1'b1;
      wmem_addr <= addr_cnt;
      data_s1   <= (state == FILL) ? in : buf_rd;
      last_s1   <= sf_wrap;
      done_s1   <= sf_wrap & nf_wrap;
    end else begin
      addr_v <= 1'b0;
    end
  end

  // Stage 2: activation beat, aligned with the weight memory read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_out  <= '0;
      act_v    <= 1'b0;
      act_last <= 1'b0;
      vec_done <= 1'b0;
    end else begin
      act_out  <= data_s1;
      act_v    <= addr_v;
      act_last <= last_s1 & addr_v;
      vec_done <= done_s1 & addr_v;
    end
  end

endmodule

// File: tb/tb_mvau_act_sched.sv
// Directed bench for mvau_act_sched: a default SF=4/NF=3 instance with an
// expected-beat scoreboard, and an SF=2/NF=1 instance checked cycle by cycle.
module tb_mvau_act_sched;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT 0: TI=8, SF=4, NF=3 ----------------
  logic [7:0] in_d;
  logic       in_v, in_rdy, out_rdy;
  logic [3:0] wmem_addr;
  logic       addr_v;
  logic [7:0] act_out;
  logic       act_v, act_last, vec_done, busy;

  mvau_act_sched #(.TI(8), .SF(4), .NF(3)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_d),
    .in_v      (in_v),
    .in_rdy    (in_rdy),
    .out_rdy   (out_rdy),
    .wmem_addr (wmem_addr),
    .addr_v    (addr_v),
    .act_out   (act_out),
    .act_v     (act_v),
    .act_last  (act_last),
    .vec_done  (vec_done),
    .busy      (busy)
  );

  // ---------------- DUT 1: TI=8, SF=2, NF=1 ----------------
  logic [7:0] b_in;
  logic       b_in_v, b_in_rdy, b_out_rdy;
  logic [0:0] b_wmem_addr;
  logic       b_addr_v;
  logic [7:0] b_act_out;
  logic       b_act_v, b_act_last, b_vec_done, b_busy;

  mvau_act_sched #(.TI(8), .SF(2), .NF(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (b_in),
    .in_v      (b_in_v),
    .in_rdy    (b_in_rdy),
    .out_rdy   (b_out_rdy),
    .wmem_addr (b_wmem_addr),
    .addr_v    (b_addr_v),
    .act_out   (b_act_out),
    .act_v     (b_act_v),
    .act_last  (b_act_last),
    .vec_done  (b_vec_done),
    .busy      (b_busy)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] exp_addr_q[$];
  logic [9:0] exp_q[$];        // {vec_done, act_last, act_out}
  logic       prev_addr_v = 1'b0;
  logic       s_addr_v, s_act_v, s_busy;
  logic [3:0] s_wmem_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected beats for one vector: addresses 0..11, words replayed 3 times.
  task automatic push_vec(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input logic [7:0] w3);
    logic [7:0] w[4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int nf = 0; nf < 3; nf++) begin
      for (int sf = 0; sf < 4; sf++) begin
        exp_addr_q.push_back(4'(nf * 4 + sf));
        exp_q.push_back({(sf == 3 && nf == 2), (sf == 3), w[sf]});
      end
    end
  endtask

  // Compare the beats visible on DUT 0 against the expected queues.
  task automatic monitor();
    logic [9:0] e;
    if (addr_v) begin
      if (exp_addr_q.size() == 0) chk("addr_extra", 32'(1), 32'(0));
      else chk("wmem_addr", 32'(wmem_addr), 32'(exp_addr_q.pop_front()));
    end
    if (act_v) begin
      chk("act_lat", 32'(prev_addr_v), 32'(1));
      if (exp_q.size() == 0) chk("act_extra", 32'(1), 32'(0));
      else begin
        e = exp_q.pop_front();
        chk("act_out", 32'(act_out), 32'(e[7:0]));
        chk("act_last", 32'(act_last), 32'(e[8]));
        chk("vec_done", 32'(vec_done), 32'(e[9]));
      end
    end else begin
      chk("flags_idle", 32'({act_last, vec_done}), 32'(0));
    end
    prev_addr_v = addr_v;
  endtask

  // ---------------- driver ----------------
  // Sample the previous edge's outputs, then drive this cycle's inputs.
  task automatic tick(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    monitor();
    s_addr_v    = addr_v;
    s_wmem_addr = wmem_addr;
    s_act_v     = act_v;
    s_busy      = busy;
    in_v    = v;
    in_d    = d;
    out_rdy = r;
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_addr_v"}, 32'(addr_v), 32'(0));
    chk({tag, "_wmem_addr"}, 32'(wmem_addr), 32'(0));
    chk({tag, "_act_v"}, 32'(act_v), 32'(0));
    chk({tag, "_act_out"}, 32'(act_out), 32'(0));
    chk({tag, "_flags"}, 32'({act_last, vec_done, busy}), 32'(0));
  endtask

  task automatic chk_sb_empty(input string tag);
    chk(tag, 32'(exp_q.size() + exp_addr_q.size()), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] pat;
    int         skid;
    rst_n = 1'b1; in_v = 1'b0; in_d = '0; out_rdy = 1'b1;
    b_in_v = 1'b0; b_in = '0; b_out_rdy = 1'b1;

    // 1. Reset asserted between edges clears outputs at once.
    #3 rst_n = 1'b0;
    #1;
    chk_cleared("rst");
    chk("rst_b_outs", 32'({b_addr_v, b_act_v, b_busy, b_wmem_addr, b_act_out}), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick(1'b0, 8'h00, 1'b1);
      chk("idle_in_rdy", 32'(in_rdy), 32'(1));
      chk("idle_addr_v", 32'(s_addr_v), 32'(0));
      chk("idle_act_v", 32'(s_act_v), 32'(0));
    end

    // 2. Contiguous vector, full replay.
    push_vec(8'h10, 8'h11, 8'h12, 8'h13);
    for (int t = 0; t < 16; t++) begin
      tick(t < 4, 8'(8'h10 + t), 1'b1);
      chk("contig_in_rdy", 32'(in_rdy), 32'(t < 4 || t >= 12));
      chk("contig_busy", 32'(s_busy), 32'(t >= 4 && t <= 11));
    end
    chk_sb_empty("contig_sb_empty");

    // 3. Backpressure for 3 cycles at replay beat 6.
    push_vec(8'h20, 8'h21, 8'h22, 8'h23);
    skid = 0;
    for (int t = 0; t < 20; t++) begin
      tick(t < 4, 8'(8'h20 + t), !(t >= 6 && t <= 8));
      if (t >= 7 && t <= 9) begin
        chk("stall_addr_v", 32'(s_addr_v), 32'(0));
        chk("stall_hold", 32'(s_wmem_addr), 32'(5));
        if (s_act_v) skid++;
      end
    end
    chk("stall_skid_le2", 32'(skid <= 2), 32'(1));
    chk_sb_empty("stall_sb_empty");

    // 4. Input bubbles during FILL: valid pattern 1,0,1,1,0,1.
    pat = 6'b101101;
    push_vec(8'h30, 8'h32, 8'h33, 8'h35);
    for (int t = 0; t < 20; t++) begin
      if (t < 6) tick(pat[t], 8'(8'h30 + t), 1'b1);
      else       tick(1'b0, 8'h00, 1'b1);
      if (t < 6) chk("bubble_in_rdy", 32'(in_rdy), 32'(1));
      if (t == 2 || t == 5) chk("bubble_addr_v", 32'(s_addr_v), 32'(0));
    end
    chk_sb_empty("bubble_sb_empty");

    // 5. NF=1, SF=2 instance: six streaming words, never leaves FILL.
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      if (t >= 1 && t <= 6) begin
        chk("nf1_addr_v", 32'(b_addr_v), 32'(1));
        chk("nf1_wmem_addr", 32'(b_wmem_addr), 32'((t - 1) % 2));
      end
      if (t >= 2 && t <= 7) begin
        chk("nf1_act_out", 32'(b_act_out), 32'(8'h60 + t - 2));
        chk("nf1_act_last", 32'(b_act_last), 32'((t - 2) % 2 == 1));
        chk("nf1_vec_done", 32'(b_vec_done), 32'((t - 2) % 2 == 1));
      end
      chk("nf1_busy", 32'(b_busy), 32'(0));
      b_in_v = (t < 6);
      b_in   = 8'(8'h60 + t);
      #1;
      chk("nf1_in_rdy", 32'(b_in_rdy), 32'(1));
    end
    b_in_v = 1'b0;

    // 6. Async reset mid-REPLAY at address 7, then a fresh vector.
    push_vec(8'h40, 8'h41, 8'h42, 8'h43);
    for (int t = 0; t < 9; t++) tick(t < 4, 8'(8'h40 + t), 1'b1);
    chk("pre_rst_addr", 32'(s_wmem_addr), 32'(7));
    chk("pre_rst_busy", 32'(s_busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk_cleared("midrst");
    chk("midrst_in_rdy", 32'(in_rdy), 32'(1));
    exp_q.delete();
    exp_addr_q.delete();
    prev_addr_v = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    push_vec(8'h50, 8'h51, 8'h52, 8'h53);
    for (int t = 0; t < 18; t++) begin
      tick(t < 4, 8'(8'h50 + t), 1'b1);
      if (t == 1) begin
        chk("post_rst_addr_v", 32'(s_addr_v), 32'(1));
        chk("post_rst_addr0", 32'(s_wmem_addr), 32'(0));
      end
    end
    chk_sb_empty("post_rst_sb_empty");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
